// File: rtl/bullet_palette_arbiter_pkg.sv
// bullet_gfx_pkg: shared bullet graphics types and the palette colour-key index.
package bullet_gfx_pkg;
  typedef logic [3:0] pal_idx_t;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;
  localparam pal_idx_t PAL_TRANSPARENT_IDX = 4'd1;
endpackage

// File: rtl/bullet_palette_arbiter_if.sv
// bullet_palette_arbiter_if: requester, palette and response signals of the palette arbiter.
// Ports (slave = arbiter side): in frame_start, req, req_index, pal_red/green/blue;
// out gnt, pal_index, rsp_valid, rsp_id, rsp_red/green/blue, rsp_transparent.
interface bullet_palette_arbiter_if #(parameter int NUM_REQ = 4);
  import bullet_gfx_pkg::*;
  localparam int IW = $clog2(NUM_REQ);
  logic                   frame_start;
  logic [NUM_REQ-1:0]     req;
  logic [4*NUM_REQ-1:0]   req_index;
  logic [NUM_REQ-1:0]     gnt;
  pal_idx_t               pal_index;
  logic [3:0]             pal_red;
  logic [3:0]             pal_green;
  logic [3:0]             pal_blue;
  logic                   rsp_valid;
  logic [IW-1:0]          rsp_id;
  logic [3:0]             rsp_red;
  logic [3:0]             rsp_green;
  logic [3:0]             rsp_blue;
  logic                   rsp_transparent;
  modport master (
    output frame_start, req, req_index, pal_red, pal_green, pal_blue,
    input  gnt, pal_index, rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue, rsp_transparent
  );
  modport slave (
    input  frame_start, req, req_index, pal_red, pal_green, pal_blue,
    output gnt, pal_index, rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue, rsp_transparent
  );
endinterface

// File: rtl/bullet_palette_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick, first set req bit searching cyclically from ptr.
// Ports: i_req request vector, i_ptr search start; o_gnt one-hot grant, o_granted encoded, o_any.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_granted,
  output logic                 o_any
);
  localparam int IW = $clog2(N);
  localparam logic [IW:0] NL = (IW+1)'(N);
  logic [IW:0] w_sum;
  logic [IW:0] w_pos;
  // One extra bit on the sum so the wrap is an explicit compare against N,
  // which keeps non-power-of-two requester counts correct.
  always_comb begin
    o_gnt = '0;
    o_granted = '0;
    o_any = 1'b0;
    w_sum = '0;
    w_pos = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      w_pos = w_sum >= NL ? w_sum - NL : w_sum;
      if (!o_any && i_req[w_pos[IW-1:0]]) begin
        o_any = 1'b1;
        o_granted = w_pos[IW-1:0];
        o_gnt[w_pos[IW-1:0]] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bullet_palette_arbiter.sv
// bullet_palette_arbiter: round-robin sharing of the bullet palette with a registered colour response.
// Ports: Clk, Reset (async, active-high); bus (slave modport) carries requests, palette
// index/colour and the tagged response.
module bullet_palette_arbiter
  import bullet_gfx_pkg::*;
#(
  parameter int       NUM_REQ         = 4,
  parameter pal_idx_t TRANSPARENT_IDX = PAL_TRANSPARENT_IDX
) (
  input logic Clk,
  input logic Reset,
  bullet_palette_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_granted;
  logic               w_any;
  pal_idx_t           w_idx;
  rgb12_t             w_pal;
  logic [IW-1:0]      r_ptr;
  logic               r_valid;
  logic [IW-1:0]      r_id;
  rgb12_t             r_rgb;
  logic               r_transparent;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .i_req     (bus.req),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_granted (w_granted),
    .o_any     (w_any)
  );
  assign w_idx = w_any ? bus.req_index[4*w_granted +: 4] : '0;
  assign w_pal = '{r: bus.pal_red, g: bus.pal_green, b: bus.pal_blue};
  // frame_start overrides the grant advance; the grant this cycle still used the old pointer.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_ptr <= '0;
      r_valid <= 1'b0;
      r_id <= '0;
      r_rgb <= '0;
      r_transparent <= 1'b0;
    end else begin
      r_ptr <= bus.frame_start ? '0 :
               !w_any ? r_ptr :
               w_granted == IW'(NUM_REQ-1) ? '0 : w_granted + IW'(1);
      r_valid <= w_any;
      if (w_any) begin
        r_id <= w_granted;
        r_rgb <= w_pal;
        r_transparent <= w_idx == TRANSPARENT_IDX;
      end
    end
  end
  assign bus.gnt = w_gnt;
  assign bus.pal_index = w_idx;
  assign bus.rsp_valid = r_valid;
  assign bus.rsp_id = r_id;
  assign bus.rsp_red = r_rgb.r;
  assign bus.rsp_green = r_rgb.g;
  assign bus.rsp_blue = r_rgb.b;
  assign bus.rsp_transparent = r_transparent;
endmodule

// File: tb/tb_bullet_palette_arbiter.sv
// tb_bullet_palette_arbiter: directed checks of grant order, response timing, frame_start and reset.
module tb_bullet_palette_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [3:0] idx_tab [4] = '{4'h0, 4'h3, 4'h1, 4'h7};
  bullet_palette_arbiter_if #(.NUM_REQ(N)) bus ();
  bullet_palette_arbiter #(.NUM_REQ(N)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] lut(input logic [3:0] idx);
    return idx == 4'h0 ? 12'h922 :
           idx == 4'h1 ? 12'hF0F :
           idx == 4'h7 ? 12'hFFF :
           idx == 4'h3 ? 12'h4A6 : {idx, idx, idx};
  endfunction
  assign {bus.pal_red, bus.pal_green, bus.pal_blue} = lut(bus.pal_index);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_rsp(input string tag, input logic [1:0] id, input logic [3:0] idx);
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
    check({tag, "_rgb"}, 32'({bus.rsp_red, bus.rsp_green, bus.rsp_blue}), 32'(lut(idx)));
    check({tag, "_tr"}, 32'(bus.rsp_transparent), 32'(idx == 4'h1));
  endtask
  initial begin
    bus.req = '0;
    bus.frame_start = 1'b0;
    bus.req_index = {idx_tab[3], idx_tab[2], idx_tab[1], idx_tab[0]};
    #2;
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rgb", 32'({bus.rsp_red, bus.rsp_green, bus.rsp_blue}), 32'h0);
    check("rst_tr", 32'(bus.rsp_transparent), 32'd0);
    check("rst_gnt_idle", 32'(bus.gnt), 32'h0);
    check("rst_pal_idle", 32'(bus.pal_index), 32'h0);
    bus.req = 4'b0100;
    #1;
    check("rst_gnt_comb", 32'(bus.gnt), 32'h4);
    check("rst_pal_comb", 32'(bus.pal_index), 32'h1);
    bus.req = '0;
    #5;
    rst = 1'b0;
    tick();
    bus.req = 4'b0001;
    #1;
    check("single_gnt", 32'(bus.gnt), 32'h1);
    check("single_pal", 32'(bus.pal_index), 32'h0);
    tick();
    check_rsp("single", 2'd0, 4'h0);
    bus.req = '0;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    check("idle_valid", 32'(bus.rsp_valid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      bus.req = 4'b1111;
      #1;
      check("rr_gnt", 32'(bus.gnt), 32'(1 << (k % 4)));
      check("rr_pal", 32'(bus.pal_index), 32'(idx_tab[k % 4]));
      tick();
      check_rsp("rr", 2'(k % 4), idx_tab[k % 4]);
    end
    bus.req = 4'b0010;
    #1;
    check("fs_setup_gnt", 32'(bus.gnt), 32'h2);
    tick();
    bus.req = 4'b1011;
    bus.frame_start = 1'b1;
    #1;
    check("fs_same_gnt", 32'(bus.gnt), 32'h8);
    tick();
    bus.frame_start = 1'b0;
    #1;
    check("fs_next_gnt", 32'(bus.gnt), 32'h1);
    tick();
    bus.req = 4'b0010;
    #1;
    check("fs2_setup_gnt", 32'(bus.gnt), 32'h2);
    tick();
    bus.req = 4'b0111;
    bus.frame_start = 1'b1;
    #1;
    check("fs2_same_gnt", 32'(bus.gnt), 32'h4);
    tick();
    bus.frame_start = 1'b0;
    bus.req = 4'b1111;
    #1;
    check("fs2_next_gnt", 32'(bus.gnt), 32'h1);
    tick();
    bus.req = 4'b0100;
    #1;
    check("pre_idle_gnt", 32'(bus.gnt), 32'h4);
    tick();
    check_rsp("pre_idle", 2'd2, 4'h1);
    bus.req = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("idle_gnt", 32'(bus.gnt), 32'h0);
      check("idle_pal", 32'(bus.pal_index), 32'h0);
      tick();
      check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("idle_rgb_hold", 32'({bus.rsp_red, bus.rsp_green, bus.rsp_blue}), 32'hF0F);
      check("idle_tr_hold", 32'(bus.rsp_transparent), 32'd1);
      check("idle_id_hold", 32'(bus.rsp_id), 32'd2);
    end
    bus.req = 4'b1111;
    #1;
    check("post_idle_gnt", 32'(bus.gnt), 32'h8);
    tick();
    check_rsp("post_idle", 2'd3, 4'h7);
    check("burst_gnt", 32'(bus.gnt), 32'h1);
    tick();
    check_rsp("burst", 2'd0, 4'h0);
    #1;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(bus.rsp_valid), 32'd0);
    check("arst_id", 32'(bus.rsp_id), 32'd0);
    check("arst_rgb", 32'({bus.rsp_red, bus.rsp_green, bus.rsp_blue}), 32'h0);
    check("arst_tr", 32'(bus.rsp_transparent), 32'd0);
    check("arst_gnt", 32'(bus.gnt), 32'h1);
    #1;
    rst = 1'b0;
    check("rel_gnt", 32'(bus.gnt), 32'h1);
    tick();
    check_rsp("rel", 2'd0, 4'h0);
    check("rel_next_gnt", 32'(bus.gnt), 32'h2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bullet_palette_arbiter.md
# bullet_palette_arbiter

Round-robin arbiter that shares the single 16-entry bullet colour palette among several sprite requesters (player/enemy bullet renderers) in the pixel pipeline. Each cycle it grants at most one requester, drives that requester's 4-bit colour index onto the shared palette, and returns the registered 12-bit RGB colour one cycle later. The response is tagged with the requester ID and a transparency flag. It sits between the bullet sprite ROM readers and the frame compositor.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- TRANSPARENT_IDX, 4'd1, palette index treated as the colour key (magenta F0F)

Ports:
- Clk  in  1  system clock; the only clock
- Reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of frame; realigns the round-robin pointer
- req  in  NUM_REQ  per-requester lookup request, level
- req_index  in  4*NUM_REQ  colour index of requester i at bits [4i+3:4i]
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req
- pal_index  out  4  index driven to the shared palette
- pal_red, pal_green, pal_blue  in  4 each  palette combinational output for pal_index
- rsp_valid  out  1  registered response strobe
- rsp_id  out  $clog2(NUM_REQ)  requester that owns the response
- rsp_red, rsp_green, rsp_blue  out  4 each  registered colour
- rsp_transparent  out  1  1 when the granted index equals TRANSPARENT_IDX

## Operation
- State: round-robin pointer ptr (range 0..NUM_REQ-1); response registers.
- Grant: the first i with req[i]=1, searching cyclically from ptr upward. gnt is one-hot, or all-zero when req=0.
- pal_index = req_index of the granted requester. It is 4'd0 when there is no grant.
- Pointer update on grant: ptr <= (granted+1) mod NUM_REQ. With no grant, ptr holds.
- frame_start: ptr <= 0 next cycle. The grant in that same cycle still uses the current ptr. frame_start wins over the grant update.
- Response capture on grant:
  - rsp_valid <= 1
  - rsp_id <= granted
  - rsp_rgb <= pal_rgb
  - rsp_transparent <= (pal_index == TRANSPARENT_IDX)
- Response with no grant: rsp_valid <= 0. Other rsp_* hold their last values.
- Fairness: a continuously asserted requester is granted within NUM_REQ cycles.
- A requester keeping req high after its grant is treated as a new request.
- No backpressure: the consumer must accept rsp every cycle rsp_valid=1.
- Out-of-range width: NUM_REQ not a power of two. The pointer wrap uses an explicit compare, not truncation.

## Timing
- Reset values: ptr=0, rsp_valid=0, rsp_id=0, rsp_red/green/blue=0, rsp_transparent=0. gnt and pal_index follow req combinationally, also during reset.
- Latency: req/gnt in cycle N produces rsp_valid in cycle N+1. Throughput is one lookup per cycle.
- Reset asserted mid-operation: the pending response is dropped and outputs take their reset values immediately. First grant after release searches from 0.
- Palette path is combinational from pal_index to pal_*. The capture register closes the timing path.

## Structure
- Shared package bullet_gfx_pkg:
  - typedef rgb12_t (struct of three 4-bit fields)
  - typedef pal_idx_t (logic [3:0])
  - constant PAL_TRANSPARENT_IDX = 4'd1
- Sub-module rr_pick:
  - purely combinational
  - inputs: req vector, ptr
  - outputs: one-hot gnt, encoded granted, any
  - reusable for the tank sprite arbiter
- Palette instance lives outside this block. The top connects pal_index and pal_* to it.

## Test plan
- Reset, then req=4'b0001 with index0=4'h0 -> gnt=0001, next cycle rsp_valid=1, rsp_id=0, rgb=9,2,2, rsp_transparent=0.
- req=4'b1111, all held 8 cycles -> grants in order 0,1,2,3,0,1,2,3; rsp_id follows one cycle later.
- Requester 2 with index 4'h1 -> rsp rgb=F,0,F, rsp_transparent=1. Index 4'h7 -> rgb=F,F,F, transparent=0.
- ptr=2, req=4'b1011, frame_start pulsed the same cycle -> this cycle grants 3. Next cycle (req unchanged) grants 0, not 1.
- req=0 for 3 cycles after activity -> gnt=0, pal_index=0, rsp_valid=0, rsp_rgb holds last value, ptr unchanged.
- Reset asserted asynchronously mid-burst (req=4'b1111) -> rsp_valid drops to 0 without a clock edge. After release, the first grant is requester 0.
